// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: drives a req/addr_ok/data_ok data bus, builds store lanes,
// extracts and extends load data, and stalls the pipeline until the access completes.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_enM,
  input  logic        mem_wrM,
  input  logic [1:0]  mem_sizeM,
  input  logic        mem_signedM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        adelM,
  output logic        adesM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} stateT;

  stateT       state, nextState;
  logic [1:0]  effSize;
  logic        misaligned, validAccess;
  logic [3:0]  curWstrb;
  logic [31:0] curWdata;
  logic        latWr, latSigned;
  logic [1:0]  latSize;
  logic [31:0] latAddr, latWdata, loadValue;
  logic [3:0]  latWstrb;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;

  // Reserved size 11 behaves exactly like a word access.
  assign effSize     = (mem_sizeM == 2'b11) ? 2'b10 : mem_sizeM;
  assign misaligned  = ((effSize == 2'b01) && aluoutM[0]) ||
                       ((effSize == 2'b10) && (aluoutM[1:0] != 2'b00));
  assign validAccess = mem_enM && !misaligned;

  always_comb begin
    curWstrb = 4'b0000;
    curWdata = writedataM;
    case (effSize)
      2'b00: begin
        curWdata = {4{writedataM[7:0]}};
        if (mem_wrM) curWstrb = 4'b0001 << aluoutM[1:0];
      end
      2'b01: begin
        curWdata = {2{writedataM[15:0]}};
        if (mem_wrM) curWstrb = aluoutM[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        if (mem_wrM) curWstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    loadByte = data_rdata[7:0];
    case (latAddr[1:0])
      2'b01:   loadByte = data_rdata[15:8];
      2'b10:   loadByte = data_rdata[23:16];
      2'b11:   loadByte = data_rdata[31:24];
      default: loadByte = data_rdata[7:0];
    endcase
    loadHalf = latAddr[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (latSize)
      2'b00:   loadValue = {{24{latSigned & loadByte[7]}}, loadByte};
      2'b01:   loadValue = {{16{latSigned & loadHalf[15]}}, loadHalf};
      default: loadValue = data_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // The payload is captured on the first request cycle so the M inputs may change afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latWr     <= 1'b0;
      latSigned <= 1'b0;
      latSize   <= 2'b00;
      latAddr   <= 32'h0;
      latWdata  <= 32'h0;
      latWstrb  <= 4'h0;
    end else if (state == IDLE && validAccess) begin
      latWr     <= mem_wrM;
      latSigned <= mem_signedM;
      latSize   <= effSize;
      latAddr   <= aluoutM;
      latWdata  <= curWdata;
      latWstrb  <= curWstrb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            readdataM <= 32'h0;
    else if (state == DATA && data_data_ok && !latWr)   readdataM <= loadValue;
  end

  // Everything combinational is forced low while reset is held.
  always_comb begin
    nextState  = state;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = 2'b00;
    data_addr  = 32'h0;
    data_wdata = 32'h0;
    data_wstrb = 4'h0;
    stallM     = 1'b0;
    adelM      = 1'b0;
    adesM      = 1'b0;
    if (!rst) begin
      adelM = mem_enM && misaligned && !mem_wrM;
      adesM = mem_enM && misaligned && mem_wrM;
      case (state)
        IDLE: begin
          if (validAccess) begin
            data_req   = 1'b1;
            data_wr    = mem_wrM;
            data_size  = effSize;
            data_addr  = aluoutM;
            data_wdata = curWdata;
            data_wstrb = curWstrb;
            stallM     = 1'b1;
            nextState  = data_addr_ok ? DATA : ADDR;
          end
        end
        ADDR: begin
          data_req   = 1'b1;
          data_wr    = latWr;
          data_size  = latSize;
          data_addr  = latAddr;
          data_wdata = latWdata;
          data_wstrb = latWstrb;
          stallM     = 1'b1;
          if (data_addr_ok) nextState = DATA;
        end
        DATA: begin
          stallM = 1'b1;
          if (data_data_ok) nextState = DONE;
        end
        default: nextState = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a reference model pushes expected bus payloads and
// load results when a transaction is driven; they are popped and compared as the DUT responds.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_enM, mem_wrM, mem_signedM;
  logic [1:0]  mem_sizeM;
  logic [31:0] aluoutM, writedataM;
  logic [31:0] readdataM;
  logic        stallM, adelM, adesM;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  wstrb;
    logic        wr;
    logic [1:0]  size;
  } expT;

  expT         expQ[$];
  logic [31:0] lastRead = 32'h0;
  int          checkCount = 0;
  int          errorCount = 0;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .mem_enM(mem_enM), .mem_wrM(mem_wrM), .mem_sizeM(mem_sizeM),
    .mem_signedM(mem_signedM), .aluoutM(aluoutM), .writedataM(writedataM),
    .readdataM(readdataM), .stallM(stallM), .adelM(adelM), .adesM(adesM),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic expT model(input logic wr, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] rd, input logic [31:0] prev);
    expT e;
    logic [31:0] shifted;
    e.addr  = addr;
    e.wr    = wr;
    e.size  = (size == 2'b11) ? 2'b10 : size;
    shifted = rd >> (8 * addr[1:0]);
    case (e.size)
      2'b00: begin
        e.wstrb = 4'b0001 << addr[1:0];
        e.wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        e.rdata = sgn ? {{24{shifted[7]}}, shifted[7:0]} : {24'h0, shifted[7:0]};
      end
      2'b01: begin
        e.wstrb = addr[1] ? 4'b1100 : 4'b0011;
        e.wdata = {wd[15:0], wd[15:0]};
        e.rdata = sgn ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]};
      end
      default: begin
        e.wstrb = 4'b1111;
        e.wdata = wd;
        e.rdata = rd;
      end
    endcase
    if (wr) e.rdata = prev;
    else    e.wstrb = 4'b0000;
    return e;
  endfunction

  // One full aligned access; the slave answers after the requested delays.
  task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] rd, input int addrDelay, input int dataDelay);
    expT e, got;
    int  stalls = 0;
    e = model(wr, size, sgn, addr, wd, rd, lastRead);
    expQ.push_back(e);
    lastRead = e.rdata;
    for (int k = 0; k <= addrDelay; k++) begin
      @(negedge clk);
      if (k == 0) begin
        mem_enM = 1'b1; mem_wrM = wr; mem_sizeM = size; mem_signedM = sgn;
        aluoutM = addr; writedataM = wd;
      end else begin
        aluoutM = ~addr; writedataM = ~wd;
      end
      data_addr_ok = (k == addrDelay);
      data_data_ok = 1'b0;
      #1;
      if (k == 0) got = expQ.pop_front();
      checkOutput("req", data_req, 1);
      checkOutput("addr", data_addr, got.addr);
      checkOutput("wstrb", data_wstrb, got.wstrb);
      checkOutput("wr", data_wr, got.wr);
      checkOutput("size", data_size, got.size);
      if (got.wr) checkOutput("wdata", data_wdata, got.wdata);
      if (stallM) stalls++;
    end
    for (int j = 0; j <= dataDelay; j++) begin
      @(negedge clk);
      data_addr_ok = 1'b0;
      data_data_ok = (j == dataDelay);
      data_rdata   = (j == dataDelay) ? rd : ~rd;
      #1;
      checkOutput("reqData", data_req, 0);
      if (stallM) stalls++;
    end
    @(negedge clk);
    data_data_ok = 1'b0;
    data_rdata   = 32'hDEADBEEF;
    mem_enM      = 1'b0;
    #1;
    checkOutput("stallDone", stallM, 0);
    checkOutput("stallCycles", stalls, 2 + addrDelay + dataDelay);
    checkOutput("readdata", readdataM, got.rdata);
  endtask

  task automatic misalignTest(input logic wr, input logic [1:0] size, input logic [31:0] addr);
    @(negedge clk);
    mem_enM = 1'b1; mem_wrM = wr; mem_sizeM = size; mem_signedM = 1'b0; aluoutM = addr;
    #1;
    checkOutput("adel", adelM, !wr);
    checkOutput("ades", adesM, wr);
    checkOutput("reqMis", data_req, 0);
    checkOutput("stallMis", stallM, 0);
    @(negedge clk);
    mem_enM = 1'b0;
    #1;
    checkOutput("readMis", readdataM, lastRead);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    mem_enM = 1'b1; mem_wrM = 1'b0; mem_sizeM = 2'b10; mem_signedM = 1'b0;
    aluoutM = 32'h3002; writedataM = 32'h0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    #2;
    checkOutput("rstRead", readdataM, 0);
    checkOutput("rstStall", stallM, 0);
    checkOutput("rstReq", data_req, 0);
    checkOutput("rstAdel", adelM, 0);
    @(negedge clk);
    rst = 1'b0;
    mem_enM = 1'b0;

    $display("[TB] loads with immediate handshakes");
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 32'h80AA55CC, 0, 0);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h1003, 32'h0, 32'h80AA55CC, 0, 0);

    $display("[TB] stores");
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h2002, 32'h1234ABCD, 32'h0, 0, 0);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h2021, 32'h000000A5, 32'h0, 1, 0);

    $display("[TB] delayed word load");
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h3000, 32'h0, 32'hCAFEF00D, 3, 1);

    $display("[TB] misaligned accesses");
    misalignTest(1'b0, 2'b10, 32'h3002);
    misalignTest(1'b1, 2'b01, 32'h2001);
    misalignTest(1'b0, 2'b11, 32'h3001);

    $display("[TB] back-to-back and half loads");
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h0, 0, 0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h11223344, 0, 0);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h8001F00F, 0, 2);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h8001F00F, 0, 0);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h14, 32'h0, 32'h0000A5A5, 2, 0);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h20, 32'h55667788, 32'h0, 0, 0);

    $display("[TB] reset during data phase");
    @(negedge clk);
    mem_enM = 1'b1; mem_wrM = 1'b0; mem_sizeM = 2'b10; mem_signedM = 1'b0;
    aluoutM = 32'h40; data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
    #1;
    checkOutput("stallInData", stallM, 1);
    rst = 1'b1;
    #1;
    checkOutput("rstMidStall", stallM, 0);
    checkOutput("rstMidRead", readdataM, 0);
    checkOutput("rstMidReq", data_req, 0);
    lastRead = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    mem_enM = 1'b0;
    @(negedge clk);
    data_data_ok = 1'b1;
    data_rdata = 32'h12345678;
    #1;
    checkOutput("lateStall", stallM, 0);
    @(negedge clk);
    data_data_ok = 1'b0;
    #1;
    checkOutput("lateRead", readdataM, 0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h41, 32'h0, 32'h0000BB00, 0, 0);

    checkOutput("queueEmpty", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store engine for the five-stage MIPS pipeline. Sits between the M-stage registers (effective address and store data) and an SRAM-like data bus with address/data handshakes. Generates byte strobes and lane-replicated store data, and extracts and extends load data for the W-stage register. Holds the pipeline with a stall until the bus transaction completes, and flags misaligned accesses without touching the bus.

## Interface
Parameters: none (fixed 32-bit address/data).

- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- mem_enM  in  1  M-stage instruction is a load or store
- mem_wrM  in  1  1 = store, 0 = load
- mem_sizeM  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- mem_signedM  in  1  loads: 1 sign-extend, 0 zero-extend
- aluoutM  in  32  effective byte address
- writedataM  in  32  store data, right-aligned
- readdataM  out  32  extended load result to W-stage register
- stallM  out  1  hold F/D/E/M; pending access not yet complete
- adelM  out  1  misaligned load (combinational)
- adesM  out  1  misaligned store (combinational)
- data_req  out  1  bus request
- data_wr  out  1  bus write
- data_size  out  2  equals mem_sizeM (11 driven as 10)
- data_addr  out  32  full byte address
- data_wdata  out  32  lane-replicated store data
- data_wstrb  out  4  byte enables (0000 for loads)
- data_addr_ok  in  1  slave accepted request this cycle
- data_data_ok  in  1  slave returns read data / write acknowledge this cycle
- data_rdata  in  32  read data, valid with data_data_ok

## Operation
- Misalignment: half with addr[0]=1, or word with addr[1:0]≠00 → adelM (load) or adesM (store) = mem_enM. No request and no stall.
- Store lanes: byte → wstrb = 0001<<addr[1:0], wdata = {4{wd[7:0]}}. Half → wstrb = addr[1] ? 1100 : 0011, wdata = {2{wd[15:0]}}. Word → 1111, wd.
- Load extract: byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16]. Extend per mem_signedM; word passes through unchanged.
- FSM states:
  - IDLE: on a valid access (mem_enM and aligned), drive data_req=1 combinationally with the payload from the M inputs and latch the payload. If data_addr_ok → DATA, else → ADDR.
  - ADDR: data_req=1 with the latched payload. On data_addr_ok → DATA.
  - DATA: data_req=0. On data_data_ok, a load latches the extended data into readdataM; a store leaves readdataM unchanged. Then → DONE.
  - DONE: no request. → IDLE unconditionally.
- stallM = (IDLE & valid access) | ADDR | DATA. It is 0 in DONE and 0 in IDLE with no valid access.
- data_data_ok in IDLE/ADDR/DONE is ignored. data_addr_ok outside a requesting cycle is ignored.
- Only one transaction is outstanding at a time.

## Timing
- Reset (async): state IDLE, readdataM=0, latched payload 0. All outputs are 0 while rst is high.
- Minimum access: cycle 0 req + addr_ok, cycle 1 data_ok, cycle 2 DONE with stallM=0. The pipeline advances at the end of cycle 2, so there are 2 stall cycles.
- Each cycle of addr_ok delay or data_ok delay adds one stall cycle.
- readdataM is registered and stable from DONE until the next load's data_ok.
- The request payload is stable from the first req cycle until addr_ok. It is taken from the latch after cycle 0, so the M inputs may be ignored.
- The M-stage instruction after DONE may issue its own request in the next IDLE cycle, which is back-to-back with no bubble.
- Reset mid-transaction: the FSM returns to IDLE immediately and any in-flight transaction is abandoned. The bus slave is reset by the same rst.

## Test plan
- lbu at 0x1003, rdata=0x80AA55CC, addr_ok/data_ok immediate → wstrb=0000, stallM high 2 cycles, readdataM=0x00000080. Repeat as lb → 0xFFFFFF80.
- sh at 0x2002, writedataM=0x1234ABCD → data_wstrb=1100, data_wdata=0xABCDABCD, data_wr=1, readdataM unchanged.
- lw at 0x3000 with addr_ok delayed 3 cycles and data_ok 2 cycles later → req held with stable addr 0x3000 for 4 cycles, stallM high 6 cycles, readdataM=rdata.
- lw at 0x3002 → adelM=1, data_req=0, stallM=0. sh at 0x2001 → adesM=1, no request.
- Back-to-back sw 0x10 then lw 0x10 → second req appears the cycle after DONE, and the load returns the slave data.
- rst asserted while in DATA → state IDLE and stallM=0 the same cycle, readdataM=0. A late data_ok after reset is ignored.
